// File: rtl/hc_dec_arbiter.sv
// hc_decode: Hamming(7,4) single-error-correcting decoder, purely combinational.
// Ports: i_code[7:1] codeword (parity at positions 1,2,4; data at 3,5,6,7),
//        o_data[4:1] corrected nibble {c7,c6,c5,c3}, o_err high when the syndrome is non-zero.
module hc_decode (
  input  logic [7:1] i_code,
  output logic [4:1] o_data,
  output logic       o_err
);

  logic [2:0] syn;
  logic [7:1] fixed;

  always_comb begin
    // Each syndrome bit covers the positions whose index has that bit set,
    // so the syndrome value is the position of a single flipped bit.
    syn[0] = ^{i_code[1], i_code[3], i_code[5], i_code[7]};
    syn[1] = ^{i_code[2], i_code[3], i_code[6], i_code[7]};
    syn[2] = ^{i_code[4], i_code[5], i_code[6], i_code[7]};
    fixed  = i_code;
    for (int b = 1; b <= 7; b++) begin
      if (syn == 3'(b)) begin
        fixed[b] = ~i_code[b];
      end
    end
    o_err  = |syn;
    o_data = {fixed[7], fixed[6], fixed[5], fixed[3]};
  end

endmodule

// hc_dec_arbiter: round-robin share of one hc_decode between two requesters.
// Latency: one cycle from accept edge to o_valid; one word per cycle while i_ready=1.
// Backpressure: o_valid && !i_ready stalls; no requester is readied and arbitration/counters hold.
// Ports: i_req_valid/i_req_data_0/1 and o_req_ready form the request handshake;
//        o_valid/i_ready/o_dec_data/o_err_flag/o_id form the result handshake;
//        i_clr_cnt clears o_err_cnt_0/1 (saturating per-requester error counts).
module hc_dec_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_req_valid,
  input  logic [7:1]       i_req_data_0,
  input  logic [7:1]       i_req_data_1,
  output logic [1:0]       o_req_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [4:1]       o_dec_data,
  output logic             o_err_flag,
  output logic             o_id,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_err_cnt_0,
  output logic [CNT_W-1:0] o_err_cnt_1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Registered state and next-state
  logic             valid_q, valid_d;
  logic [4:1]       data_q,  data_d;
  logic             err_q,   err_d;
  logic             id_q,    id_d;
  logic             last_q,  last_d;
  logic [CNT_W-1:0] cnt0_q,  cnt0_d;
  logic [CNT_W-1:0] cnt1_q,  cnt1_d;

  // Arbitration and datapath
  logic       gnt_vld;
  logic       gnt_id;
  logic       can_accept;
  logic       xfer;
  logic [7:1] dec_code;
  logic [4:1] dec_data;
  logic       dec_err;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    unique case (i_req_valid)
      2'b01:   begin gnt_vld = 1'b1; gnt_id = 1'b0;    end
      2'b10:   begin gnt_vld = 1'b1; gnt_id = 1'b1;    end
      2'b11:   begin gnt_vld = 1'b1; gnt_id = ~last_q; end
      default: begin gnt_vld = 1'b0; gnt_id = 1'b0;    end
    endcase
  end

  assign dec_code = gnt_id ? i_req_data_1 : i_req_data_0;

  hc_decode u_dec (
    .i_code (dec_code),
    .o_data (dec_data),
    .o_err  (dec_err)
  );

  assign can_accept = ~valid_q | i_ready;
  // Reset gating keeps ready low while the block is held in reset.
  assign xfer        = i_rst_n & can_accept & gnt_vld;
  assign o_req_ready = xfer ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;

    if (xfer) begin
      valid_d = 1'b1;
      data_d  = dec_data;
      err_d   = dec_err;
      id_d    = gnt_id;
      last_d  = gnt_id;
      if (dec_err) begin
        if (gnt_id) begin
          cnt1_d = (cnt1_q == CNT_MAX) ? cnt1_q : cnt1_q + 1'b1;
        end else begin
          cnt0_d = (cnt0_q == CNT_MAX) ? cnt0_q : cnt0_q + 1'b1;
        end
      end
    end else if (i_ready) begin
      // Drain only: data fields keep their last value.
      valid_d = 1'b0;
    end

    // Clear wins over a same-cycle increment.
    if (i_clr_cnt) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;  // requester 0 wins the first contention
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_dec_data  = data_q;
  assign o_err_flag  = err_q;
  assign o_id        = id_q;
  assign o_err_cnt_0 = cnt0_q;
  assign o_err_cnt_1 = cnt1_q;

endmodule

// File: tb/tb_hc_dec_arbiter.sv
module tb_hc_dec_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [7:1] d0, d1;
  logic       rdy_in;
  logic       clr;

  logic [1:0] req_ready_a, req_ready_b;
  logic       valid_a, valid_b;
  logic [4:1] data_a, data_b;
  logic       err_a, err_b;
  logic       id_a, id_b;
  logic [7:0] cnt0_a, cnt1_a;
  logic [1:0] cnt0_b, cnt1_b;

  int n_checks = 0;
  int n_fail   = 0;

  hc_dec_arbiter #(.CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid),
    .i_req_data_0(d0), .i_req_data_1(d1), .o_req_ready(req_ready_a),
    .o_valid(valid_a), .i_ready(rdy_in), .o_dec_data(data_a),
    .o_err_flag(err_a), .o_id(id_a), .i_clr_cnt(clr),
    .o_err_cnt_0(cnt0_a), .o_err_cnt_1(cnt1_a)
  );

  hc_dec_arbiter #(.CNT_W(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid),
    .i_req_data_0(d0), .i_req_data_1(d1), .o_req_ready(req_ready_b),
    .o_valid(valid_b), .i_ready(rdy_in), .o_dec_data(data_b),
    .o_err_flag(err_b), .o_id(id_b), .i_clr_cnt(clr),
    .o_err_cnt_0(cnt0_b), .o_err_cnt_1(cnt1_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference Hamming(7,4) encoder: data at positions 3,5,6,7.
  function automatic logic [7:1] enc(input logic [3:0] n);
    logic [7:1] c;
    c[3] = n[0]; c[5] = n[1]; c[6] = n[2]; c[7] = n[3];
    c[1] = c[3] ^ c[5] ^ c[7];
    c[2] = c[3] ^ c[6] ^ c[7];
    c[4] = c[5] ^ c[6] ^ c[7];
    return c;
  endfunction

  // Nearest-codeword decode: {err, nibble}. Only 0/1-bit errors are driven.
  function automatic logic [4:0] ref_dec(input logic [7:1] cw);
    logic [4:0] r;
    r = 5'd0;
    for (int n = 0; n < 16; n++) begin
      if ($countones(cw ^ enc(4'(n))) <= 1) begin
        r = {($countones(cw ^ enc(4'(n))) == 1), 4'(n)};
      end
    end
    return r;
  endfunction

  // Behavioural model of the result stage and counters
  logic       m_valid, m_err, m_id, m_last;
  logic [3:0] m_data;
  int         m_cnt0, m_cnt1, m2_cnt0, m2_cnt1;

  always @(negedge clk) begin
    logic       acc;
    logic       who;
    logic [1:0] exp_rdy;
    logic [4:0] r;
    if (!rst_n) begin
      m_valid = 0; m_err = 0; m_id = 0; m_last = 1; m_data = 0;
      m_cnt0 = 0; m_cnt1 = 0; m2_cnt0 = 0; m2_cnt1 = 0;
    end
    who = (req_valid == 2'b11) ? !m_last : req_valid[1];
    acc = rst_n && (req_valid != 2'b00) && (!m_valid || rdy_in);
    exp_rdy = acc ? (2'b01 << who) : 2'b00;

    chk("ready",    int'(req_ready_a), int'(exp_rdy));
    chk("ready2",   int'(req_ready_b), int'(exp_rdy));
    chk("valid",    int'(valid_a), int'(m_valid));
    chk("valid2",   int'(valid_b), int'(m_valid));
    chk("data",     int'(data_a),  int'(m_data));
    chk("err",      int'(err_a),   int'(m_err));
    chk("id",       int'(id_a),    int'(m_id));
    chk("cnt0",     int'(cnt0_a),  m_cnt0);
    chk("cnt1",     int'(cnt1_a),  m_cnt1);
    chk("cnt0_w2",  int'(cnt0_b),  m2_cnt0);
    chk("cnt1_w2",  int'(cnt1_b),  m2_cnt1);

    if (rst_n) begin
      if (acc) begin
        r = ref_dec(who ? d1 : d0);
        m_valid = 1; m_data = r[3:0]; m_err = r[4]; m_id = who; m_last = who;
        if (r[4]) begin
          if (who) begin
            m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
            m2_cnt1 = (m2_cnt1 < 3) ? m2_cnt1 + 1 : 3;
          end else begin
            m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
            m2_cnt0 = (m2_cnt0 < 3) ? m2_cnt0 + 1 : 3;
          end
        end
      end else if (rdy_in) begin
        m_valid = 0;
      end
      if (clr) begin
        m_cnt0 = 0; m_cnt1 = 0; m2_cnt0 = 0; m2_cnt1 = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sat_tab [5];
    sat_tab = '{1, 2, 3, 3, 3};

    rst_n = 0; req_valid = 2'b01; d0 = 7'h7F; d1 = 7'h00; rdy_in = 1; clr = 0;
    #1;
    chk("lit_rst_ready", int'(req_ready_a), 0);
    chk("lit_rst_valid", int'(valid_a), 0);
    step(); step();
    req_valid = 2'b00;
    rst_n = 1;
    step();

    // R0 clean all-ones word
    req_valid = 2'b01; d0 = 7'h7F;
    #1;
    chk("lit_t1_ready", int'(req_ready_a), 1);
    step();
    req_valid = 2'b00;
    chk("lit_t1_valid", int'(valid_a), 1);
    chk("lit_t1_data",  int'(data_a), 15);
    chk("lit_t1_err",   int'(err_a), 0);
    chk("lit_t1_id",    int'(id_a), 0);
    chk("lit_t1_cnt0",  int'(cnt0_a), 0);

    // R1 single-bit flips of all-ones
    for (int i = 0; i < 7; i++) begin
      req_valid = 2'b10; d1 = 7'h7F ^ (7'd1 << i);
      step();
      chk("lit_flip_data", int'(data_a), 15);
      chk("lit_flip_err",  int'(err_a), 1);
      chk("lit_flip_id",   int'(id_a), 1);
    end
    req_valid = 2'b00;
    chk("lit_flip_cnt1",  int'(cnt1_a), 7);
    chk("lit_flip_cnt0",  int'(cnt0_a), 0);
    chk("lit_flip_cnt1b", int'(cnt1_b), 3);
    step();

    // Continuous contention: alternate 0,1,0,1
    req_valid = 2'b11; d0 = 7'h00; d1 = 7'h7F;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lit_alt_ready", int'(req_ready_a), (i % 2 == 0) ? 1 : 2);
      step();
      chk("lit_alt_id",   int'(id_a), i % 2);
      chk("lit_alt_data", int'(data_a), (i % 2 == 0) ? 0 : 15);
    end
    req_valid = 2'b00;
    step();

    // Backpressure with contention
    req_valid = 2'b11;
    step();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lit_bp_ready", int'(req_ready_a), 0);
      chk("lit_bp_valid", int'(valid_a), 1);
      chk("lit_bp_data",  int'(data_a), 0);
      chk("lit_bp_id",    int'(id_a), 0);
      step();
    end
    rdy_in = 1;
    #1;
    chk("lit_bp_resume_ready", int'(req_ready_a), 2);
    step();
    chk("lit_bp_resume_id",   int'(id_a), 1);
    chk("lit_bp_resume_data", int'(data_a), 15);
    req_valid = 2'b00;
    step();

    // Saturation with the 2-bit counter instance
    clr = 1;
    step();
    clr = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 2'b01; d0 = 7'h7F ^ (7'd1 << i);
      step();
      chk("lit_sat_cnt0_w2", int'(cnt0_b), sat_tab[i]);
      chk("lit_sat_cnt0",    int'(cnt0_a), i + 1);
    end

    // Clear beats a same-cycle erroneous transfer
    d0 = 7'h7E; clr = 1;
    step();
    clr = 0; req_valid = 2'b00;
    chk("lit_clr_cnt0",    int'(cnt0_a), 0);
    chk("lit_clr_cnt0_w2", int'(cnt0_b), 0);
    chk("lit_clr_err",     int'(err_a), 1);
    step();

    // Async reset while stalled, then first contention goes to R0
    req_valid = 2'b10; d1 = 7'h7F;
    step();
    req_valid = 2'b00; rdy_in = 0;
    step();
    #2;
    rst_n = 0;
    #1;
    chk("lit_arst_valid",  int'(valid_a), 0);
    chk("lit_arst_valid2", int'(valid_b), 0);
    step(); step();
    rst_n = 1; rdy_in = 1; req_valid = 2'b11; d0 = 7'h00;
    #1;
    chk("lit_post_rst_ready", int'(req_ready_a), 1);
    step();
    chk("lit_post_rst_id", int'(id_a), 0);
    req_valid = 2'b00;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
